// File: rtl/sar_pkg.sv
// sar_pkg: shared constants, types and helpers for the SAR result-capture path.
//   BIT_ADC    : code width produced by the 6-bit SAR logic
//   sar_code_t : one finished conversion code
//   clog2()    : ceiling log2, used to size FIFO pointers and occupancy counts
package sar_pkg;

    localparam int BIT_ADC = 6;

    typedef logic [BIT_ADC-1:0] sar_code_t;

    // Ceiling log2 for elaboration-time sizing; clog2(1) = 0, clog2(4) = 2.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sar_sync_fifo.sv
// sar_sync_fifo: generic single-clock FIFO, DEPTH entries of WIDTH bits.
// Pointers are one bit wider than the address so full and empty are told apart
// by the MSB; they wrap naturally. DEPTH must be a power of two, >= 2.
// Ports:
//   CLK, RST  : clock, asynchronous active-high reset (pointers only)
//   PUSH      : write WR_DATA; accepted when not full, or when full and a pop
//               happens on the same edge
//   POP       : remove head entry; ignored when empty
//   WR_DATA   : entry to write
//   RD_DATA   : head entry, combinational; 0 when empty
//   FULL      : DEPTH entries held
//   EMPTY     : no entries held
//   COUNT     : occupancy, 0..DEPTH
module sar_sync_fifo
    import sar_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    PUSH,
    input  logic                    POP,
    input  logic [WIDTH-1:0]        WR_DATA,
    output logic [WIDTH-1:0]        RD_DATA,
    output logic                    FULL,
    output logic                    EMPTY,
    output logic [clog2(DEPTH):0]   COUNT
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign EMPTY = (wr_ptr == rd_ptr);
    assign FULL  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign COUNT = wr_ptr - rd_ptr;

    // A full FIFO can still take a push when the head leaves on the same edge.
    assign pop_ok  = POP && !EMPTY;
    assign push_ok = PUSH && (!FULL || pop_ok);

    assign RD_DATA = EMPTY ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage has no reset; the pointers alone decide which entries are
    // live, so clearing the array would only cost reset fan-out.
    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= WR_DATA;
    end

endmodule

// File: rtl/sar_code_fifo.sv
// sar_code_fifo: captures each finished SAR code on the rising edge of EOC and
// queues it for a slower reader, with a sticky overflow flag.
// Build option: define SAR_AVG_EN to average 2^AVG_LOG2 conversions into one
// queued code (truncating divide). Without it every conversion is queued.
// Ports:
//   CLK       : system clock, shared with the SAR logic
//   RST       : asynchronous active-high reset
//   EOC       : end-of-conversion, one or more cycles high per conversion
//   ADC_CODE  : finished code, stable while EOC is high
//   RD_EN     : pop request, ignored while RD_VALID = 0
//   OVF_CLR   : clears OVF (a new overflow on the same edge wins)
//   RD_DATA   : head-of-FIFO code, 0 when empty
//   RD_VALID  : FIFO not empty
//   COUNT     : FIFO occupancy
//   OVF       : sticky, a result was dropped because the FIFO was full
module sar_code_fifo #(
    parameter int BIT_ADC  = sar_pkg::BIT_ADC,
    parameter int DEPTH    = 4,
    parameter int AVG_LOG2 = 2
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          EOC,
    input  logic [BIT_ADC-1:0]            ADC_CODE,
    input  logic                          RD_EN,
    input  logic                          OVF_CLR,
    output logic [BIT_ADC-1:0]            RD_DATA,
    output logic                          RD_VALID,
    output logic [sar_pkg::clog2(DEPTH):0] COUNT,
    output logic                          OVF
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sar_code_fifo: DEPTH must be a power of two >= 2");
    end
    if (AVG_LOG2 < 1) begin : g_bad_avg
        $error("sar_code_fifo: AVG_LOG2 must be >= 1");
    end

    logic               eoc_d;
    logic               smp;
    logic               push;
    logic [BIT_ADC-1:0] push_data;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               drop;
    logic               ovf_q;

    // A held EOC yields one sample event: only the low-to-high step counts.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) eoc_d <= 1'b0;
        else     eoc_d <= EOC;
    end

    assign smp = EOC && !eoc_d;

`ifdef SAR_AVG_EN
    localparam int ACC_W = BIT_ADC + AVG_LOG2;

    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_sum;
    logic [AVG_LOG2-1:0] cnt;
    logic                last_smp;

    // Width is sized so that 2^AVG_LOG2 full-scale codes cannot wrap.
    assign acc_sum  = acc + ACC_W'(ADC_CODE);
    assign last_smp = &cnt;

    assign push      = smp && last_smp;
    assign push_data = acc_sum[ACC_W-1:AVG_LOG2];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc <= '0;
            cnt <= '0;
        end else if (smp) begin
            if (last_smp) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= acc_sum;
                cnt <= cnt + 1'b1;
            end
        end
    end
`else
    assign push      = smp;
    assign push_data = ADC_CODE;
`endif

    assign pop  = RD_EN && !fifo_empty;
    assign drop = push && fifo_full && !pop;

    sar_sync_fifo #(
        .WIDTH (BIT_ADC),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .PUSH    (push),
        .POP     (pop),
        .WR_DATA (push_data),
        .RD_DATA (RD_DATA),
        .FULL    (fifo_full),
        .EMPTY   (fifo_empty),
        .COUNT   (COUNT)
    );

    // Set has priority so an overflow coinciding with a clear is not lost.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)          ovf_q <= 1'b0;
        else if (drop)    ovf_q <= 1'b1;
        else if (OVF_CLR) ovf_q <= 1'b0;
    end

    assign RD_VALID = !fifo_empty;
    assign OVF      = ovf_q;

endmodule
